// File: rtl/keyscan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : keyscan_pkg                                                  |
// | Description : Shared constants, physical-to-key map, scan FSM states and   |
// |               a lowest-set-bit helper for the 4x4 CHIP-8 keypad scanner.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package keyscan_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    // Hex key found at physical position row*4+col. Rows top to bottom:
    //   1 2 3 C / 4 5 6 D / 7 8 9 E / A 0 B F
    localparam logic [3:0] KEYMAP [0:15] = '{
        4'h1, 4'h2, 4'h3, 4'hC,
        4'h4, 4'h5, 4'h6, 4'hD,
        4'h7, 4'h8, 4'h9, 4'hE,
        4'hA, 4'h0, 4'hB, 4'hF
    };

    // IDLE is the held-in-reset state: no column is driven.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2
    } scan_state_t;

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keyscan_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : keyscan_debounce                                             |
// | Description : Maps a completed physical scan to key order, requires        |
// |               DEBOUNCE_SCANS identical scans before publishing, and pulses |
// |               key_event on newly pressed keys. Optional ghost rejection    |
// |               when KEYSCAN_GHOST_REJECT_EN is defined.                     |
// | Ports       : clk, reset (sync, active-low)                                |
// |               raw[15:0]       physical scan, bit row*4+col = pressed       |
// |               scan_done       1-cycle strobe, raw is complete              |
// |               keypad_matrix   debounced state, bit n = key n               |
// |               key_event       1-cycle pulse on any 0->1 transition         |
// |               key_code        lowest newly pressed key                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module keyscan_debounce
    import keyscan_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] raw,
    input  logic        scan_done,
    output logic [15:0] keypad_matrix,
    output logic        key_event,
    output logic [3:0]  key_code
);

    localparam int c_cnt_w = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_SCANS - 1);

    logic [15:0]        r_matrix;
    logic [15:0]        r_prev;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_event;
    logic [3:0]         r_code;

    logic [15:0]        w_keys;
    logic [15:0]        w_rising;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic               w_ambiguous;

    always_comb begin
        w_keys = '0;
        for (int i = 0; i < NUM_ROWS * NUM_COLS; i++) begin
            w_keys[KEYMAP[i]] = raw[i];
        end
    end

`ifdef KEYSCAN_GHOST_REJECT_EN
    // Two rows sharing two or more columns close a loop in the diode-less
    // matrix, so at least one reported key may be phantom.
    always_comb begin
        logic [3:0] w_ov;
        w_ambiguous = 1'b0;
        w_ov        = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            for (int j = i + 1; j < NUM_ROWS; j++) begin
                w_ov = raw[i*NUM_COLS +: NUM_COLS] & raw[j*NUM_COLS +: NUM_COLS];
                if ($countones(w_ov) >= 2) w_ambiguous = 1'b1;
            end
        end
    end
`else
    assign w_ambiguous = 1'b0;
`endif

    always_comb begin
        if (w_keys != r_prev)       w_cnt_next = '0;
        else if (r_cnt == c_cnt_max) w_cnt_next = r_cnt;
        else                         w_cnt_next = r_cnt + c_cnt_w'(1);
        w_rising = w_keys & ~r_matrix;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_matrix <= '0;
            r_prev   <= '0;
            r_cnt    <= '0;
            r_event  <= 1'b0;
            r_code   <= 4'd0;
        end else begin
            r_event <= 1'b0;
            if (scan_done) begin
                if (w_ambiguous) begin
                    r_cnt <= '0;
                end else begin
                    r_prev <= w_keys;
                    r_cnt  <= w_cnt_next;
                    if (w_cnt_next == c_cnt_max && w_keys != r_matrix) begin
                        r_matrix <= w_keys;
                        if (|w_rising) begin
                            r_event <= 1'b1;
                            r_code  <= lowest_set(w_rising);
                        end
                    end
                end
            end
        end
    end

    assign keypad_matrix = r_matrix;
    assign key_event     = r_event;
    assign key_code      = r_code;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : keypad_scanner                                               |
// | Description : Scans a 4x4 CHIP-8 hex keypad by driving one column low at a |
// |               time, sampling synchronised active-low rows, and publishing  |
// |               a debounced 16-bit key matrix with press events.             |
// |               Define KEYSCAN_GHOST_REJECT_EN to drop ambiguous scans.      |
// | Ports       : clk            system clock                                  |
// |               reset          synchronous, active-low                       |
// |               col_n[3:0]     column drive, active-low                      |
// |               row_n[3:0]     row sense, active-low, asynchronous           |
// |               keypad_matrix  debounced key state, bit n = key n            |
// |               key_event      1-cycle pulse on a new press                  |
// |               key_code       lowest newly pressed key                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module keypad_scanner
    import keyscan_pkg::*;
#(
    parameter int SCAN_DIV       = 1024,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  col_n,
    input  logic [3:0]  row_n,
    output logic [15:0] keypad_matrix,
    output logic        key_event,
    output logic [3:0]  key_code
);

    localparam int c_dwell_w = $clog2(SCAN_DIV);
    // DRIVE ends one count early so SAMPLE lands on dwell == SCAN_DIV-1.
    localparam logic [c_dwell_w-1:0] c_dwell_pre = c_dwell_w'(SCAN_DIV - 2);

    logic [3:0]           r_sync1;
    logic [3:0]           r_sync2;
    scan_state_t          r_state;
    scan_state_t          w_next_state;
    logic [1:0]           r_col;
    logic [1:0]           w_col_next;
    logic [c_dwell_w-1:0] r_dwell;
    logic [c_dwell_w-1:0] w_dwell_next;
    logic [15:0]          r_phys;
    logic [15:0]          w_phys_next;
    logic [15:0]          w_sample;
    logic                 w_scan_done;
    logic [3:0]           r_col_n;
    logic [3:0]           w_col_n_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= row_n;
            r_sync2 <= r_sync1;
        end
    end

    // Current column's rows merged into the partial scan; on the last column
    // this is the complete scan handed to the debouncer in the same cycle.
    always_comb begin
        w_sample = r_phys;
        for (int r = 0; r < NUM_ROWS; r++) begin
            w_sample[r*NUM_COLS + int'(r_col)] = ~r_sync2[r];
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_col_next   = r_col;
        w_dwell_next = r_dwell;
        w_phys_next  = r_phys;
        w_scan_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_DRIVE;
            end
            ST_DRIVE: begin
                w_dwell_next = r_dwell + c_dwell_w'(1);
                if (r_dwell == c_dwell_pre) w_next_state = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                w_phys_next  = w_sample;
                w_dwell_next = '0;
                w_col_next   = r_col + 2'd1;
                w_next_state = ST_DRIVE;
                if (r_col == 2'd3) w_scan_done = 1'b1;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        w_col_n_next = (w_next_state == ST_IDLE) ? 4'hF : ~(4'b0001 << w_col_next);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_col   <= 2'd0;
            r_dwell <= '0;
            r_phys  <= '0;
            r_col_n <= 4'hF;
        end else begin
            r_state <= w_next_state;
            r_col   <= w_col_next;
            r_dwell <= w_dwell_next;
            r_phys  <= w_phys_next;
            r_col_n <= w_col_n_next;
        end
    end

    assign col_n = r_col_n;

    keyscan_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk           (clk),
        .reset         (reset),
        .raw           (w_sample),
        .scan_done     (w_scan_done),
        .keypad_matrix (keypad_matrix),
        .key_event     (key_event),
        .key_code      (key_code)
    );

endmodule
`default_nettype wire
